// File: rtl/mfp_pmod_als_pkg.sv
// Shared definitions for the PmodALS (ADC081S021) SPI read master: FSM encoding,
// frame geometry and the light-field extraction helper.
package mfp_pmod_als_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int ALS_FRAME_BITS = 16;
  localparam int ALS_DATA_MSB   = 12;
  localparam int ALS_DATA_LSB   = 5;
  localparam int ALS_LIGHT_W    = ALS_DATA_MSB - ALS_DATA_LSB + 1;

  // The sensor frames its 8-bit conversion between leading zeros and trailing padding.
  function automatic logic [ALS_LIGHT_W-1:0] als_light(input logic [ALS_FRAME_BITS-1:0] frame);
    return frame[ALS_DATA_MSB:ALS_DATA_LSB];
  endfunction

endpackage

// File: rtl/mfp_pmod_als_sck_gen.sv
// SCK half-period divider: paces SETUP/SHIFT/HOLD, generates SCK (falling edge first)
// and strobes the cycle in which SCK is driven high, plus the end of the last half-period.
module mfp_pmod_als_sck_gen
  import mfp_pmod_als_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic active_i,
  input  logic load_i,
  input  logic shift_i,
  output logic sck_o,
  output logic tick_o,
  output logic rise_o,
  output logic last_o
);

  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_N    = 2 * ALS_FRAME_BITS;
  localparam int HW      = $clog2(HP_N);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hp_q, hp_d;
  logic          sck_q, sck_d;
  logic          tick;
  logic          last_hp;

  assign tick    = active_i && (div_q == DW'(CLK_DIV - 1));
  assign last_hp = (hp_q == HW'(HP_N - 1));

  always_comb begin
    div_d = (!active_i || tick) ? '0 : div_q + 1'b1;
    hp_d  = hp_q;
    sck_d = sck_q;
    if (load_i) begin
      hp_d  = '0;
      sck_d = 1'b0;
    end else if (shift_i) begin
      if (tick) begin
        hp_d = hp_q + 1'b1;
        // SCK parks high after the final half-period instead of toggling
        if (!last_hp) sck_d = ~sck_q;
      end
    end else begin
      sck_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      hp_q  <= '0;
      sck_q <= 1'b1;
    end else begin
      div_q <= div_d;
      hp_q  <= hp_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign tick_o = tick;
  assign rise_o = shift_i && tick && !sck_q;
  assign last_o = shift_i && tick && last_hp;

endmodule

// File: rtl/mfp_pmod_als_spi_master.sv
// PmodALS SPI read master: one 16-SCK frame per sample period, raw frame + 8-bit light.
// Define MFP_PMOD_ALS_AVERAGE_EN to make light_avg a 4-sample running mean.
module mfp_pmod_als_spi_master
  import mfp_pmod_als_pkg::*;
#(
  parameter int CLK_DIV       = 8,
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  output logic                      cs,
  output logic                      sck,
  input  logic                      sdo,
  output logic [ALS_FRAME_BITS-1:0] value,
  output logic [ALS_LIGHT_W-1:0]    light,
  output logic [ALS_LIGHT_W-1:0]    light_avg,
  output logic                      value_valid,
  output logic                      busy
);

  localparam int PW = $clog2(SAMPLE_PERIOD);

  logic [1:0]                state_q, state_d;
  logic [PW-1:0]             per_q, per_d;
  logic                      pend_q, pend_d;
  logic                      cs_q, cs_d;
  logic [ALS_FRAME_BITS-1:0] value_q, value_d;
  logic [ALS_LIGHT_W-1:0]    light_q, light_d;
  logic                      vld_q, vld_d;
  logic [ALS_FRAME_BITS-1:0] shift_q;

  logic wrap, start, tick, rise, last;

  assign wrap  = (per_q == PW'(SAMPLE_PERIOD - 1));
  assign start = (state_q == ST_IDLE) && enable && pend_q;

  mfp_pmod_als_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .active_i (state_q != ST_IDLE),
    .load_i   ((state_q == ST_SETUP) && tick),
    .shift_i  (state_q == ST_SHIFT),
    .sck_o    (sck),
    .tick_o   (tick),
    .rise_o   (rise),
    .last_o   (last)
  );

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    value_d = value_q;
    light_d = light_q;
    vld_d   = 1'b0;
    per_d   = wrap ? '0 : per_q + 1'b1;
    // A single request flag: periods that elapse mid-frame collapse into one
    pend_d  = wrap ? 1'b1 : (start ? 1'b0 : pend_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          cs_d    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last) begin
          state_d = ST_HOLD;
          cs_d    = 1'b1;
          value_d = shift_q;
          light_d = als_light(shift_q);
          vld_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      pend_q  <= 1'b0;
      cs_q    <= 1'b1;
      value_q <= '0;
      light_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      cs_q    <= cs_d;
      value_q <= value_d;
      light_q <= light_d;
      vld_q   <= vld_d;
    end
  end

  // sdo has been stable for a full low half-period when SCK is about to rise
  always_ff @(posedge clock) begin
    if (rise) shift_q <= {shift_q[ALS_FRAME_BITS-2:0], sdo};
  end

`ifdef MFP_PMOD_ALS_AVERAGE_EN
  logic [ALS_LIGHT_W-1:0] h1_q, h2_q, h3_q, avg_q;
  logic [ALS_LIGHT_W+1:0] sum;

  assign sum = (ALS_LIGHT_W+2)'(light_q) + (ALS_LIGHT_W+2)'(h1_q)
             + (ALS_LIGHT_W+2)'(h2_q) + (ALS_LIGHT_W+2)'(h3_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h1_q  <= '0;
      h2_q  <= '0;
      h3_q  <= '0;
      avg_q <= '0;
    end else if (vld_q) begin
      avg_q <= sum[ALS_LIGHT_W+1:2];
      h1_q  <= light_q;
      h2_q  <= h1_q;
      h3_q  <= h2_q;
    end
  end

  assign light_avg = avg_q;
`else
  assign light_avg = light_q;
`endif

  assign cs          = cs_q;
  assign value       = value_q;
  assign light       = light_q;
  assign value_valid = vld_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mfp_pmod_als_spi_master.sv
// Scoreboard bench for mfp_pmod_als_spi_master: a sensor model serves directed frames,
// a monitor checks each value_valid against queued hand-computed expectations.
module tb_mfp_pmod_als_spi_master;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        cs;
  logic        sck;
  logic        sdo = 1'b0;
  logic [15:0] value;
  logic [7:0]  light;
  logic [7:0]  light_avg;
  logic        value_valid;
  logic        busy;

  mfp_pmod_als_spi_master #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (200)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .cs          (cs),
    .sck         (sck),
    .sdo         (sdo),
    .value       (value),
    .light       (light),
    .light_avg   (light_avg),
    .value_valid (value_valid),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] value;
    logic [7:0]  light;
    logic [7:0]  avg;
    bit          chk_avg;
    bit          chk_per;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_vld   = 0;
  int          cyc     = 0;
  logic [15:0] model_word = 16'h0000;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Sensor: presents the next bit (MSB first) on each falling SCK edge while selected.
  int bit_idx = 15;
  always @(negedge sck or posedge cs) begin
    if (cs) begin
      bit_idx = 15;
    end else if (bit_idx >= 0) begin
      sdo = model_word[bit_idx];
      bit_idx--;
    end
  end

  // Monitor
  int   cs_len   = 0;
  int   rises    = 0;
  logic prev_cs  = 1'b1;
  logic prev_sck = 1'b1;
  logic vld_prev = 1'b0;
  bit   avg_due  = 1'b0;
  logic [7:0] avg_exp = 8'h00;
  int   last_vld_cyc = -1;
  exp_t e;

  always @(negedge clock) begin
    if (!reset_n) begin
      cs_len   = 0;
      rises    = 0;
      prev_cs  = 1'b1;
      prev_sck = 1'b1;
      vld_prev = 1'b0;
      avg_due  = 1'b0;
    end else begin
      if (vld_prev) check("valid_one_cycle", 32'(value_valid), 32'd0);
      if (avg_due) begin
        check("light_avg", 32'(light_avg), 32'(avg_exp));
        avg_due = 1'b0;
      end
      if (!cs) begin
        cs_len++;
        if (sck && !prev_sck) rises++;
      end
      if (cs && !prev_cs) begin
        check("cs_low_cycles", 32'(cs_len), 32'd66);
        check("sck_rises", 32'(rises), 32'd16);
        cs_len = 0;
        rises  = 0;
      end
      if (value_valid) begin
        n_vld++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_valid");
        end else begin
          e = exp_q.pop_front();
          check("value", 32'(value), 32'(e.value));
          check("light", 32'(light), 32'(e.light));
          check("valid_at_cs_rise", 32'({prev_cs, cs}), 32'd1);
          check("busy_in_hold", 32'(busy), 32'd1);
`ifdef MFP_PMOD_ALS_AVERAGE_EN
          if (e.chk_avg) begin
            avg_due = 1'b1;
            avg_exp = e.avg;
          end
`else
          check("light_avg_eq_light", 32'(light_avg), 32'(light));
`endif
          if (e.chk_per) check("valid_period", 32'(cyc - last_vld_cyc), 32'd200);
        end
        last_vld_cyc = cyc;
      end
      vld_prev = value_valid;
      prev_cs  = cs;
      prev_sck = sck;
    end
  end

  task automatic expect_frame(input logic [15:0] w, input logic [7:0] l, input logic [7:0] a,
                              input bit ca, input bit pc);
    exp_t x;
    model_word = w;
    x.value   = w;
    x.light   = l;
    x.avg     = a;
    x.chk_avg = ca;
    x.chk_per = pc;
    exp_q.push_back(x);
  endtask

  task automatic wait_done();
    int  n0;
    bit  got;
    n0  = n_vld;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clock);
      if (n_vld != n0) got = 1'b1;
    end
    if (!got) fail_now("frame_complete");
    for (int i = 0; i < 10 && busy; i++) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic wait_cs_low();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      if (!cs) got = 1'b1;
    end
    if (!got) fail_now("cs_fall");
  endtask

  int cs_act;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sck", 32'(sck), 32'd1);
    check("rst_value", 32'(value), 32'd0);
    check("rst_light", 32'(light), 32'd0);
    check("rst_light_avg", 32'(light_avg), 32'd0);
    check("rst_valid", 32'(value_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    reset_n = 1'b1;
    enable  = 1'b1;
    expect_frame(16'h14A0, 8'hA5, 8'h00, 1'b0, 1'b0); wait_done();
    expect_frame(16'h1FE0, 8'hFF, 8'h00, 1'b0, 1'b1); wait_done();
    expect_frame(16'hFFFF, 8'hFF, 8'h00, 1'b0, 1'b1); wait_done();
    expect_frame(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1); wait_done();

    // Drop enable mid-SHIFT: the frame still completes
    expect_frame(16'h0A5A, 8'h52, 8'h00, 1'b0, 1'b1);
    wait_cs_low();
    repeat (20) @(negedge clock);
    enable = 1'b0;
    wait_done();

    cs_act = 0;
    repeat (450) begin
      @(negedge clock);
      if (!cs) cs_act++;
    end
    check("no_cs_while_disabled", 32'(cs_act), 32'd0);

    // A period elapsed while disabled, so the frame starts right after re-enable
    expect_frame(16'h1234, 8'h91, 8'h00, 1'b0, 1'b0);
    enable = 1'b1;
    @(negedge clock);
    check("start_after_reenable", 32'(cs), 32'd0);
    wait_done();

    // Asynchronous reset in SHIFT half-period 10
    model_word = 16'h0F0F;
    wait_cs_low();
    repeat (22) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cs", 32'(cs), 32'd1);
    check("arst_sck", 32'(sck), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_value", 32'(value), 32'd0);
    check("arst_valid", 32'(value_valid), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("post_rst_value", 32'(value), 32'd0);

    expect_frame(16'h0200, 8'h10, 8'h04, 1'b1, 1'b0); wait_done();
    expect_frame(16'h0400, 8'h20, 8'h0C, 1'b1, 1'b1); wait_done();
    expect_frame(16'h0600, 8'h30, 8'h18, 1'b1, 1'b1); wait_done();
    expect_frame(16'h0800, 8'h40, 8'h28, 1'b1, 1'b1); wait_done();

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
